// File: rtl/customlogic_pkg.sv
// Shared types and widths for the custom-logic datapath stages.
package customlogic_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } wb_state_t;

    localparam int unsigned SDRAM_ADDR_W = 26;
    localparam int unsigned PIX_W        = 32;
    localparam int unsigned DIM_W        = 13;

endpackage

// File: rtl/wb_fifo.sv
// First-word-fall-through FIFO with registered storage; head is visible while not empty.
module wb_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0]      wptr_q, wptr_d;
    logic [PtrW:0]      rptr_q, rptr_d;
    logic [Width-1:0]   mem_q [Depth];
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign rdata = mem_q[rptr_q[PtrW-1:0]];

    always_comb begin
        wptr_d = wptr_q + {{PtrW{1'b0}}, do_push};
        rptr_d = rptr_q + {{PtrW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[PtrW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pixel_writeback.sv
// Buffers filtered pixels and writes one frame sequentially to SDRAM.
// Optional write-stall counter: define PIXEL_WRITEBACK_STALL_CNT_EN.
module pixel_writeback
    import customlogic_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = customlogic_pkg::SDRAM_ADDR_W,
    parameter int unsigned DATA_W     = customlogic_pkg::PIX_W,
    parameter int unsigned DIM_W      = customlogic_pkg::DIM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] finish_addr_sdram,
    input  logic [DIM_W-1:0]  image_width,
    input  logic [DIM_W-1:0]  image_height,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              sdram_write_en,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [DATA_W-1:0] sdram_wdata,
    input  logic              sdram_waitrequest,
    output logic              busy,
    output logic              done,
    output logic [31:0]       stall_cycles
);
    localparam int unsigned CntW = 2 * DIM_W;

    wb_state_t          state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CntW-1:0]    total_q;
    logic [CntW-1:0]    count_q;
    logic [CntW-1:0]    acc_q;
    logic               busy_q;
    logic               done_q;

    logic               run;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_head;
    logic [CntW-1:0]    frame_total;

    assign frame_total = {{DIM_W{1'b0}}, image_width} * {{DIM_W{1'b0}}, image_height};

    assign run            = (state_q == StRun);
    // Input is closed once the whole frame has been accepted.
    assign pix_ready      = run && !fifo_full && (acc_q != total_q);
    assign push           = pix_valid && pix_ready;
    assign sdram_write_en = run && !fifo_empty;
    assign pop            = sdram_write_en && !sdram_waitrequest;
    assign sdram_address  = addr_q;
    assign sdram_wdata    = sdram_write_en ? fifo_head : '0;
    assign busy           = busy_q;
    assign done           = done_q;

    wb_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (pix_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            total_q <= '0;
            count_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        addr_q  <= finish_addr_sdram;
                        total_q <= frame_total;
                        count_q <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (push) begin
                        acc_q <= acc_q + CntW'(1);
                    end
                    if (pop) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        count_q <= count_q + CntW'(1);
                    end
                    // First clause only fires for an empty frame.
                    if ((count_q == total_q) || (pop && (count_q + CntW'(1) == total_q))) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef PIXEL_WRITEBACK_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            stall_q <= '0;
        end else if (sdram_write_en && sdram_waitrequest && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pixel_writeback.sv
// Directed bench for pixel_writeback with a count/queue frame model checked every cycle.
module tb_pixel_writeback;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [25:0] finish_addr_sdram = '0;
    logic [12:0] image_width = '0;
    logic [12:0] image_height = '0;
    logic        pix_valid = 1'b0;
    logic [31:0] pix_data = '0;
    logic        pix_ready;
    logic        sdram_write_en;
    logic [25:0] sdram_address;
    logic [31:0] sdram_wdata;
    logic        sdram_waitrequest = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] stall_cycles;

    pixel_writeback dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .finish_addr_sdram (finish_addr_sdram),
        .image_width       (image_width),
        .image_height      (image_height),
        .pix_valid         (pix_valid),
        .pix_data          (pix_data),
        .pix_ready         (pix_ready),
        .sdram_write_en    (sdram_write_en),
        .sdram_address     (sdram_address),
        .sdram_wdata       (sdram_wdata),
        .sdram_waitrequest (sdram_waitrequest),
        .busy              (busy),
        .done              (done),
        .stall_cycles      (stall_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: phase 0 idle, 1 running, 2 done pulse.
    int          m_phase = 0;
    logic [25:0] m_addr = '0;
    logic [25:0] m_total = '0;
    logic [25:0] m_acc = '0;
    logic [25:0] m_wr = '0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_q[$];

    // Observations from the DUT pins for directed checks.
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          last_commit_cyc = 0;
    int          done_cnt = 0;
    int          we_cnt = 0;
    int          acc_cnt = 0;
    logic [57:0] wlog[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic exp_we;
        logic exp_rdy;
        logic commit;
        int   nxt;
        if (rst) begin
            m_phase = 0;
            m_addr  = '0;
            m_total = '0;
            m_acc   = '0;
            m_wr    = '0;
            m_stall = '0;
            m_q.delete();
        end
        exp_we  = (m_phase == 1) && (m_acc != m_wr);
        exp_rdy = (m_phase == 1) && ((m_acc - m_wr) < DEPTH) && (m_acc < m_total);
        chk("pix_ready", pix_ready, exp_rdy);
        chk("sdram_write_en", sdram_write_en, exp_we);
        chk("sdram_address", sdram_address, m_addr);
        chk("sdram_wdata", sdram_wdata, (exp_we && m_q.size() > 0) ? m_q[0] : 32'd0);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_phase == 2);
`ifdef PIXEL_WRITEBACK_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, m_stall);
`else
        chk("stall_cycles", stall_cycles, 32'd0);
`endif

        if (sdram_write_en && !sdram_waitrequest) begin
            wlog.push_back({sdram_address, sdram_wdata});
            last_commit_cyc = cyc;
        end
        if (sdram_write_en) we_cnt++;
        if (pix_valid && pix_ready) acc_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end

        if (!rst) begin
            nxt = m_phase;
            if (m_phase == 0) begin
                if (start) begin
                    m_addr  = finish_addr_sdram;
                    m_total = {13'd0, image_width} * {13'd0, image_height};
                    m_acc   = '0;
                    m_wr    = '0;
                    m_stall = '0;
                    m_q.delete();
                    nxt = 1;
                end
            end else if (m_phase == 1) begin
                commit = exp_we && !sdram_waitrequest;
                if (exp_we && sdram_waitrequest && m_stall != 32'hFFFF_FFFF) m_stall++;
                if ((m_wr == m_total) || (commit && (m_wr + 26'd1 == m_total))) nxt = 2;
                if (exp_rdy && pix_valid) begin
                    m_q.push_back(pix_data);
                    m_acc++;
                end
                if (commit) begin
                    void'(m_q.pop_front());
                    m_wr++;
                    m_addr++;
                end
            end else begin
                nxt = 0;
            end
            m_phase = nxt;
        end
    end

    task automatic start_frame(input logic [25:0] a, input logic [12:0] w, input logic [12:0] h);
        finish_addr_sdram = a;
        image_width  = w;
        image_height = h;
        start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_pix(input logic [31:0] d);
        bit ok = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = pix_ready;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        chk("push_timeout", ok, 1'b1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_timeout", seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    int d0;
    int a0;
    int w0;
    logic [31:0] exp_stall;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", sdram_address, 26'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic 2x2 frame
        wlog.delete();
        d0 = done_cnt;
        start_frame(26'h100, 13'd2, 13'd2);
        for (int i = 0; i < 4; i++) push_pix(32'hA0 + i);
        wait_done();
        chk("basic_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("basic_write", wlog[i], {26'h100 + 26'(i), 32'hA0 + 32'(i)});
        chk("basic_done_cnt", done_cnt - d0, 1);
        chk("basic_done_cyc", done_cyc - last_commit_cyc, 1);

        // Backpressure: 12 stalled cycles while 10 pixels are offered
        wlog.delete();
        sdram_waitrequest = 1'b1;
        a0 = acc_cnt;
        start_frame(26'h1000, 13'd10, 13'd1);
        fork
            for (int i = 0; i < 10; i++) push_pix(32'hB0 + i);
            begin
                repeat (11) @(posedge clk);
                @(negedge clk);
                chk("bp_accepted_while_stalled", acc_cnt - a0, 8);
                @(posedge clk);
                #1 sdram_waitrequest = 1'b0;
            end
        join
        wait_done();
        chk("bp_nwrites", wlog.size(), 10);
        for (int i = 0; i < 10 && i < wlog.size(); i++)
            chk("bp_write", wlog[i], {26'h1000 + 26'(i), 32'hB0 + 32'(i)});

        // Zero frame
        w0 = we_cnt;
        start_frame(26'h300, 13'd0, 13'd5);
        wait_done();
        chk("zero_no_writes", we_cnt - w0, 0);
        chk("zero_done_latency", done_cyc - start_cyc, 2);

        // Reset after 3 of 16 writes
        wlog.delete();
        start_frame(26'h500, 13'd4, 13'd4);
        for (int i = 0; i < 3; i++) push_pix(32'h50 + i);
        @(posedge clk);
        #1;
        chk("rst_mid_writes_before", wlog.size(), 3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_we", sdram_write_en, 1'b0);
        chk("rst_mid_addr", sdram_address, 26'd0);
        chk("rst_mid_wdata", sdram_wdata, 32'd0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ready", pix_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        wlog.delete();
        start_frame(26'h2000, 13'd1, 13'd1);
        push_pix(32'h77);
        wait_done();
        chk("rst_after_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) chk("rst_after_write", wlog[0], {26'h2000, 32'h77});

        // Ignored start during run, excess pixels, back-to-back frame
        wlog.delete();
        d0 = done_cnt;
        sdram_waitrequest = 1'b1;
        a0 = acc_cnt;
        start_frame(26'h600, 13'd3, 13'd1);
        push_pix(32'hC0);
        finish_addr_sdram = 26'h700;
        image_width  = 13'd9;
        image_height = 13'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        push_pix(32'hC1);
        push_pix(32'hC2);
        pix_valid = 1'b1;
        pix_data  = 32'hDEAD;
        repeat (4) @(posedge clk);
        #1 pix_valid = 1'b0;
        chk("excess_accepted", acc_cnt - a0, 3);
        sdram_waitrequest = 1'b0;
        wait_done();
        start_frame(26'h800, 13'd2, 13'd1);
        push_pix(32'hD0);
        push_pix(32'hD1);
        wait_done();
        chk("b2b_nwrites", wlog.size(), 5);
        for (int i = 0; i < 3 && i < wlog.size(); i++)
            chk("ign_write", wlog[i], {26'h600 + 26'(i), 32'hC0 + 32'(i)});
        if (wlog.size() >= 5) begin
            chk("b2b_write0", wlog[3], {26'h800, 32'hD0});
            chk("b2b_write1", wlog[4], {26'h801, 32'hD1});
        end
        chk("b2b_done_cnt", done_cnt - d0, 2);

        // Address wrap with 5 stalled cycles
        wlog.delete();
        sdram_waitrequest = 1'b1;
        start_frame(26'h3FFFFFF, 13'd2, 13'd1);
        push_pix(32'hE0);
        push_pix(32'hE1);
        repeat (4) @(posedge clk);
        #1 sdram_waitrequest = 1'b0;
        wait_done();
        chk("wrap_nwrites", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("wrap_write0", wlog[0], {26'h3FFFFFF, 32'hE0});
            chk("wrap_write1", wlog[1], {26'h0, 32'hE1});
        end
`ifdef PIXEL_WRITEBACK_STALL_CNT_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        chk("wrap_stall_cycles", stall_cycles, exp_stall);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_writeback.md
# pixel_writeback

Downstream stage of the custom-logic datapath. Accepts post-filter 32-bit pixels from the filter/SRAM stage through a valid/ready handshake, buffers them in a small FIFO, and writes them to SDRAM sequentially starting at the frame's finish address. Counts written pixels against `image_width * image_height` and pulses `done` when the frame is fully committed. It is the only block that drives SDRAM write cycles for output image data.

## Interface
- `FIFO_DEPTH`, 8: pixel FIFO entries; power of two, at least 2.
- `ADDR_W`, 26: SDRAM word-address width.
- `DATA_W`, 32: pixel and SDRAM data width.
- `DIM_W`, 13: image dimension width.

- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle frame start pulse, already edge-detected upstream.
- `finish_addr_sdram` in ADDR_W: first output word address; sampled on accepted `start`.
- `image_width` in DIM_W: pixels per row; sampled on accepted `start`.
- `image_height` in DIM_W: rows; sampled on accepted `start`.
- `pix_valid` in 1: upstream pixel present.
- `pix_data` in DATA_W: filtered pixel.
- `pix_ready` out 1: block accepts a pixel this cycle.
- `sdram_write_en` out 1: write request.
- `sdram_address` out ADDR_W: write word address.
- `sdram_wdata` out DATA_W: write data.
- `sdram_waitrequest` in 1: SDRAM stalls the current write.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the frame is complete.
- `stall_cycles` out 32: write-stall counter (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start` high latches `finish_addr_sdram` into the address register and loads `total = image_width * image_height` (2*DIM_W bits, unsigned, no truncation). Clears the write count. Transitions to RUN.
- RUN: `pix_ready = !fifo_full`. A pixel is accepted when `pix_valid && pix_ready`.
- RUN: `sdram_write_en = !fifo_empty`; `sdram_wdata` = FIFO head; `sdram_address` = address register.
- A write is committed when `sdram_write_en && !sdram_waitrequest`. On commit: pop FIFO, increment address by 1 (wraps modulo 2^ADDR_W), increment write count.
- RUN exits to DONE in the cycle after the commit that makes `count == total`.
- If `total == 0`, RUN exits to DONE on its first cycle and no writes are issued.
- DONE: `done = 1` for exactly one cycle, then IDLE.
- Pixels arriving beyond `total` are not accepted: `pix_ready` is forced low once `accepted == total`.
- `start` in RUN or DONE is ignored. A new frame requires IDLE.
- `pix_ready` is low in IDLE and DONE.
- Simultaneous push and pop on a full FIFO: push is refused because `pix_ready` is low. Simultaneous push and pop on a non-full FIFO both occur, and occupancy is unchanged.

## Timing
- Reset values: state IDLE; `pix_ready`, `sdram_write_en`, `busy` and `done` = 0; `sdram_address` = 0; `sdram_wdata` = 0; `stall_cycles` = 0; FIFO empty.
- `rst` mid-frame aborts immediately. No `done` is issued and buffered pixels are discarded.
- FIFO is first-word-fall-through with registered storage. A pixel accepted at edge N is presented on `sdram_*` in cycle N+1 at the earliest.
- While `sdram_waitrequest` is high, `sdram_write_en`, `sdram_address` and `sdram_wdata` are held stable.
- `busy` rises the cycle after an accepted `start` and falls with the `done` pulse cycle's end.
- Sustained throughput is one pixel per cycle with no stalls.

## Configuration
- `PIXEL_WRITEBACK_STALL_CNT_EN` defined: `stall_cycles` increments each cycle with `sdram_write_en && sdram_waitrequest`, saturating at 2^32-1, and clears on an accepted `start`.
- Macro undefined: the counter logic is absent and `stall_cycles` is tied to 0.

## Structure
- Shared package `customlogic_pkg` holds:
  - `wb_state_t` enum (IDLE, RUN, DONE);
  - constants `SDRAM_ADDR_W = 26`, `PIX_W = 32`, `DIM_W = 13`.
- Sub-module `wb_fifo`: synchronous FWFT FIFO parameterised by depth and width, with `full`, `empty`, `push` and `pop` ports.
- The FSM, counters and address register stay in `pixel_writeback`.

## Test plan
- Basic frame: width=2, height=2, `finish_addr_sdram`=0x100, four pixels 0xA0..0xA3, waitrequest low -> writes 0xA0..0xA3 to 0x100..0x103 in order; `done` pulses once, the cycle after the fourth commit.
- Backpressure: `sdram_waitrequest` held high for 12 cycles while 10 pixels are offered -> address and data stay stable; `pix_ready` drops after 8 pixels are accepted; all 10 pixels are later written in order.
- Zero frame: width=0, height=5 -> no `sdram_write_en`; `done` pulses 2 cycles after `start`.
- Reset mid-frame: `rst` asserted after 3 of 16 writes -> all outputs 0 and state IDLE. A following 1x1 frame writes exactly one word at the new `finish_addr_sdram`.
- Ignored start and excess input: `start` re-pulsed during RUN -> no effect. Pixels offered after `total` are accepted -> `pix_ready` stays low. A back-to-back second frame after `done` completes normally.
- Address wrap: `finish_addr_sdram`=0x3FFFFFF, 2 pixels -> writes to 0x3FFFFFF then 0x0000000. With `PIXEL_WRITEBACK_STALL_CNT_EN` and waitrequest high for 5 cycles -> `stall_cycles` = 5.
